// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - default raster timing, FSM state encoding and counter width helper
package video_pkg;

  localparam int DEF_DW       = 24;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FILL = 2'd1,
    RUN       = 2'd2
  } state_t;

  // A one-value counter still needs one bit.
  function automatic int cnt_w(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - h/v raster counters with unregistered active, sync and frame-boundary decodes
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic act,
  output logic hs,
  output logic vs,
  output logic fbound,
  output logic origin
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = cnt_w(H_TOTAL);
  localparam int VW      = cnt_w(V_TOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  int            hc;
  int            vc;

  // Counters sit at the origin while stopped so a restart always begins a full frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign hc = int'(h_cnt);
  assign vc = int'(v_cnt);

  assign act    = (hc < H_ACTIVE) && (vc < V_ACTIVE);
  assign hs     = (hc >= H_ACTIVE + H_FP) && (hc < H_ACTIVE + H_FP + H_SYNC);
  assign vs     = (vc >= V_ACTIVE + V_FP) && (vc < V_ACTIVE + V_FP + V_SYNC);
  assign fbound = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign origin = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/video_fifo_reader.sv
// rtl/video_fifo_reader.sv - pixel-clock FIFO consumer: run FSM, per-pixel pops, registered video outputs
module video_fifo_reader
  import video_pkg::*;
#(
  parameter int   DW       = DEF_DW,
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  output logic          fifo_rd_en,
  input  logic [DW-1:0] fifo_rd_data,
  input  logic          fifo_empty,
  input  logic          fifo_aempty,
  output logic          vid_hs,
  output logic          vid_vs,
  output logic          vid_de,
  output logic [DW-1:0] vid_data,
  output logic          frame_start,
  output logic          underflow,
  input  logic          underflow_clr
);

  state_t        state;
  state_t        state_nxt;
  logic          act;
  logic          hs_act;
  logic          vs_act;
  logic          fbound;
  logic          origin;
  logic          starve;
  logic          de_nxt;
  logic          hs_nxt;
  logic          vs_nxt;
  logic          fs_nxt;
  logic          ufl_nxt;
  logic [DW-1:0] data_nxt;

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (state != IDLE),
    .act     (act),
    .hs      (hs_act),
    .vs      (vs_act),
    .fbound  (fbound),
    .origin  (origin)
  );

  // The FIFO head is valid in the same cycle, so the pop and the data capture share one edge.
  assign fifo_rd_en = (state == RUN) && act && !fifo_empty;
  assign starve     = (state == RUN) && act && fifo_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    de_nxt    = 1'b0;
    hs_nxt    = ~HS_POL;
    vs_nxt    = ~VS_POL;
    fs_nxt    = 1'b0;
    data_nxt  = '0;
    ufl_nxt   = underflow_clr ? 1'b0 : underflow;

    case (state)
      IDLE: begin
        if (enable) state_nxt = WAIT_FILL;
      end
      WAIT_FILL: begin
        if (fbound) begin
          if (!enable)          state_nxt = IDLE;
          else if (!fifo_aempty) state_nxt = RUN;
        end
      end
      RUN: begin
        // A starved pixel blanks the rest of the frame; the refill check waits for the boundary.
        if (starve)                  state_nxt = WAIT_FILL;
        else if (fbound && !enable)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (state != IDLE) begin
      de_nxt = act;
      hs_nxt = hs_act ? HS_POL : ~HS_POL;
      vs_nxt = vs_act ? VS_POL : ~VS_POL;
      fs_nxt = origin;
    end

    if (fifo_rd_en) data_nxt = fifo_rd_data;
    if (starve)     ufl_nxt  = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vid_de      <= 1'b0;
      vid_hs      <= ~HS_POL;
      vid_vs      <= ~VS_POL;
      vid_data    <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      vid_de      <= de_nxt;
      vid_hs      <= hs_nxt;
      vid_vs      <= vs_nxt;
      vid_data    <= data_nxt;
      frame_start <= fs_nxt;
      underflow   <= ufl_nxt;
    end
  end

endmodule

// File: tb/tb_video_fifo_reader.sv
// tb/tb_video_fifo_reader.sv - directed bench for video_fifo_reader with a same-clock FIFO model
module tb_video_fifo_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic        fifo_rd_en;
  logic [23:0] fifo_rd_data = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_aempty = 1'b1;
  logic        vid_hs;
  logic        vid_vs;
  logic        vid_de;
  logic [23:0] vid_data;
  logic        frame_start;
  logic        underflow;
  logic        underflow_clr = 1'b0;

  int total = 0;
  int bad = 0;
  int wr_limit = 0;
  int wr_count = 0;
  logic [23:0] q[$];

  always #5 clk = ~clk;

  video_fifo_reader #(
    .DW(24), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .fifo_aempty(fifo_aempty),
    .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de), .vid_data(vid_data),
    .frame_start(frame_start), .underflow(underflow), .underflow_clr(underflow_clr)
  );

  // FIFO model, depth 64, almost-empty below 33 words; writer emits 0,1,2,... up to wr_limit.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      wr_count     <= 0;
      fifo_empty   <= 1'b1;
      fifo_aempty  <= 1'b1;
      fifo_rd_data <= '0;
    end else begin
      if (fifo_rd_en && q.size() > 0) void'(q.pop_front());
      if (wr_count < wr_limit && q.size() < 64) begin
        q.push_back(24'(wr_count));
        wr_count <= wr_count + 1;
      end
      fifo_empty   <= (q.size() == 0);
      fifo_aempty  <= (q.size() < 33);
      fifo_rd_data <= (q.size() > 0) ? q[0] : 24'd0;
    end
  end

  function automatic logic exp_de(input int i);
    return ((i % 14) < 8) && ((i / 14) < 4);
  endfunction

  function automatic int pix(input int i);
    return (i / 14) * 8 + (i % 14);
  endfunction

  task automatic wait_fs(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    enable = 1'b0;
    wr_limit = 0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++;
    if ({vid_de, vid_hs, vid_vs, frame_start, underflow, fifo_rd_en} !== 6'b011000) begin
      bad++;
      $display("FAIL reset_ctrl got de/hs/vs/fs/ufl/rd=%b exp=011000",
               {vid_de, vid_hs, vid_vs, frame_start, underflow, fifo_rd_en});
    end
    total++;
    if (vid_data !== 24'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", vid_data); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wr_limit = 40;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      total++;
      if (fifo_rd_en !== 1'b0 || vid_de !== 1'b0 || vid_hs !== 1'b1 || vid_vs !== 1'b1 || frame_start !== 1'b0) begin
        bad++;
        $display("FAIL idle_outputs cyc=%0d got rd/de/hs/vs/fs=%b%b%b%b%b exp=00110",
                 i, fifo_rd_en, vid_de, vid_hs, vid_vs, frame_start);
      end
    end
  endtask

  task automatic test_fill();
    bit ok;
    logic [23:0] ed;
    enable = 1'b1;
    wait_fs(20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL fill_fs_timeout got=none exp=frame_start"); end
    for (int i = 0; i < 98; i++) begin
      total++;
      if (vid_de !== exp_de(i) || vid_data !== 24'd0 || frame_start !== (i == 0)) begin
        bad++;
        $display("FAIL blank_frame i=%0d got de=%b data=%h fs=%b exp de=%b data=0 fs=%b",
                 i, vid_de, vid_data, frame_start, exp_de(i), (i == 0));
      end
      if (i < 97) begin
        total++;
        if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL blank_pop i=%0d got=%b exp=0", i, fifo_rd_en); end
      end
      @(negedge clk);
    end
    for (int i = 0; i < 98; i++) begin
      ed = exp_de(i) ? 24'(pix(i)) : 24'd0;
      total++;
      if (vid_de !== exp_de(i) || vid_data !== ed || frame_start !== (i == 0)) begin
        bad++;
        $display("FAIL run_frame i=%0d got de=%b data=%h fs=%b exp de=%b data=%h fs=%b",
                 i, vid_de, vid_data, frame_start, exp_de(i), ed, (i == 0));
      end
      if (i == 97) wr_limit = 1000000;
      @(negedge clk);
    end
  endtask

  task automatic test_timing();
    logic [23:0] ed;
    logic ehs, evs;
    int de_n = 0, hs_n = 0, vs_n = 0;
    for (int i = 0; i < 98; i++) begin
      ehs = !(((i % 14) >= 10) && ((i % 14) < 12));
      evs = !((i / 14) == 5);
      ed  = exp_de(i) ? 24'(32 + pix(i)) : 24'd0;
      total++;
      if (vid_hs !== ehs || vid_vs !== evs || vid_de !== exp_de(i) || vid_data !== ed || underflow !== 1'b0) begin
        bad++;
        $display("FAIL timing i=%0d got hs=%b vs=%b de=%b data=%h ufl=%b exp hs=%b vs=%b de=%b data=%h ufl=0",
                 i, vid_hs, vid_vs, vid_de, vid_data, underflow, ehs, evs, exp_de(i), ed);
      end
      if (vid_de === 1'b1) de_n++;
      if (vid_hs === 1'b0) hs_n++;
      if (vid_vs === 1'b0) vs_n++;
      @(negedge clk);
    end
    total++;
    if (de_n != 32) begin bad++; $display("FAIL de_count got=%0d exp=32", de_n); end
    total++;
    if (hs_n != 14) begin bad++; $display("FAIL hs_count got=%0d exp=14", hs_n); end
    total++;
    if (vs_n != 14) begin bad++; $display("FAIL vs_count got=%0d exp=14", vs_n); end
  endtask

  task automatic test_underflow();
    bit ok;
    logic [23:0] ed;
    logic eu;
    @(negedge clk);
    enable = 1'b0;
    wr_limit = 0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wr_limit = 52;
    repeat (60) @(negedge clk);
    enable = 1'b1;
    wait_fs(20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL ufl_fs_timeout got=none exp=frame_start"); end
    repeat (196) @(negedge clk);
    for (int i = 0; i < 98; i++) begin
      ed = (exp_de(i) && i < 32) ? 24'(32 + pix(i)) : 24'd0;
      eu = (i >= 32);
      total++;
      if (vid_de !== exp_de(i) || vid_data !== ed || underflow !== eu) begin
        bad++;
        $display("FAIL starve_frame i=%0d got de=%b data=%h ufl=%b exp de=%b data=%h ufl=%b",
                 i, vid_de, vid_data, underflow, exp_de(i), ed, eu);
      end
      if (i >= 32) begin
        total++;
        if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL starve_pop i=%0d got=%b exp=0", i, fifo_rd_en); end
      end
      underflow_clr = (i == 31);
      if (i == 97) wr_limit = 92;
      @(negedge clk);
    end
    for (int i = 0; i < 98; i++) begin
      total++;
      if (vid_de !== exp_de(i) || vid_data !== 24'd0 || underflow !== 1'b1) begin
        bad++;
        $display("FAIL refill_frame i=%0d got de=%b data=%h ufl=%b exp de=%b data=0 ufl=1",
                 i, vid_de, vid_data, underflow, exp_de(i));
      end
      if (i < 97) begin
        total++;
        if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL refill_pop i=%0d got=%b exp=0", i, fifo_rd_en); end
      end
      @(negedge clk);
    end
    total++;
    if (frame_start !== 1'b1 || vid_de !== 1'b1 || vid_data !== 24'd52) begin
      bad++;
      $display("FAIL resume got fs=%b de=%b data=%h exp fs=1 de=1 data=000034", frame_start, vid_de, vid_data);
    end
  endtask

  task automatic test_underflow_clr();
    wr_limit = 1000000;
    total++;
    if (underflow !== 1'b1) begin bad++; $display("FAIL ufl_sticky got=%b exp=1", underflow); end
    underflow_clr = 1'b1;
    @(negedge clk);
    underflow_clr = 1'b0;
    total++;
    if (underflow !== 1'b0) begin bad++; $display("FAIL ufl_clr got=%b exp=0", underflow); end
    @(negedge clk);
    total++;
    if (underflow !== 1'b0) begin bad++; $display("FAIL ufl_clr_hold got=%b exp=0", underflow); end
  endtask

  task automatic test_disable();
    bit ok;
    logic [23:0] ed;
    wait_fs(200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL disable_fs_timeout got=none exp=frame_start"); end
    for (int i = 0; i < 98; i++) begin
      ed = exp_de(i) ? 24'(84 + pix(i)) : 24'd0;
      total++;
      if (vid_de !== exp_de(i) || vid_data !== ed) begin
        bad++;
        $display("FAIL disable_frame i=%0d got de=%b data=%h exp de=%b data=%h", i, vid_de, vid_data, exp_de(i), ed);
      end
      if (i == 20) enable = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < 120; i++) begin
      total++;
      if (fifo_rd_en !== 1'b0 || vid_de !== 1'b0 || vid_hs !== 1'b1 || vid_vs !== 1'b1 || frame_start !== 1'b0) begin
        bad++;
        $display("FAIL after_disable cyc=%0d got rd/de/hs/vs/fs=%b%b%b%b%b exp=00110",
                 i, fifo_rd_en, vid_de, vid_hs, vid_vs, frame_start);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midline();
    bit ok;
    enable = 1'b1;
    wait_fs(20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL midline_fs_timeout got=none exp=frame_start"); end
    repeat (98) @(negedge clk);
    total++;
    if (frame_start !== 1'b1) begin bad++; $display("FAIL midline_run_fs got=%b exp=1", frame_start); end
    repeat (17) @(negedge clk);
    total++;
    if (vid_de !== 1'b1 || vid_data !== 24'd127 || fifo_rd_en !== 1'b1) begin
      bad++;
      $display("FAIL midline_pre got de=%b data=%h rd=%b exp de=1 data=00007f rd=1", vid_de, vid_data, fifo_rd_en);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({vid_de, vid_hs, vid_vs, frame_start, underflow, fifo_rd_en} !== 6'b011000 || vid_data !== 24'd0) begin
      bad++;
      $display("FAIL midline_reset got de/hs/vs/fs/ufl/rd=%b data=%h exp=011000 data=0",
               {vid_de, vid_hs, vid_vs, frame_start, underflow, fifo_rd_en}, vid_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_timing();
    test_underflow();
    test_underflow_clr();
    test_disable();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
